// File: rtl/mandelbrot_engine_mc.sv
// Multi-context Mandelbrot engine: NUM_CTX pixel contexts share one iteration datapath round-robin.
// Optional MANDEL_CARDIOID_EN: pixels inside the main cardioid or period-2 bulb skip iteration.
module mandelbrot_engine_mc #(
    parameter int DATA_WIDTH  = 25,
    parameter int FRACT_WIDTH = 20,
    parameter int ITER_WIDTH  = 16,
    parameter int PIXEL_WIDTH = 10,
    parameter int NUM_CTX     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ITER_WIDTH-1:0]        iterations_max,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_cr,
    input  logic signed [DATA_WIDTH-1:0] in_ci,
    input  logic [PIXEL_WIDTH-1:0]       in_xpixel,
    input  logic [PIXEL_WIDTH-1:0]       in_ypixel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ITER_WIDTH-1:0]        out_iterations,
    output logic                         out_escaped,
    output logic [PIXEL_WIDTH-1:0]       out_xpixel,
    output logic [PIXEL_WIDTH-1:0]       out_ypixel,
    output logic                         busy
);
    localparam int PW     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int SQ_W   = 2 * DATA_WIDTH + 1;
    // 4.0 expressed at product scaling (2*FRACT_WIDTH fractional bits)
    localparam logic signed [SQ_W-1:0] ESC_LIM = SQ_W'(4) <<< (2 * FRACT_WIDTH);

    typedef enum logic [1:0] {CTX_FREE, CTX_RUN, CTX_DONE} ctx_state_t;

    ctx_state_t                   state_q [NUM_CTX];
    logic signed [DATA_WIDTH-1:0] zr_q    [NUM_CTX];
    logic signed [DATA_WIDTH-1:0] zi_q    [NUM_CTX];
    logic signed [DATA_WIDTH-1:0] cr_q    [NUM_CTX];
    logic signed [DATA_WIDTH-1:0] ci_q    [NUM_CTX];
    logic [ITER_WIDTH-1:0]        iter_q  [NUM_CTX];
    logic                         esc_q   [NUM_CTX];
    logic [PIXEL_WIDTH-1:0]       xpix_q  [NUM_CTX];
    logic [PIXEL_WIDTH-1:0]       ypix_q  [NUM_CTX];
    logic [PW-1:0]                ptr_q;

    ctx_state_t state_nxt;
    logic accept, step, finish, out_load, escape, load_inside;

    logic signed [PROD_W-1:0]     zr2, zi2, zrzi;
    logic signed [SQ_W-1:0]       sq, diff, dbl;
    logic signed [DATA_WIDTH-1:0] zr_nxt, zi_nxt;

    function automatic logic signed [DATA_WIDTH-1:0] trunc_shift(input logic signed [SQ_W-1:0] v);
        logic signed [SQ_W-1:0] s;
        s = v >>> FRACT_WIDTH;
        return s[DATA_WIDTH-1:0];
    endfunction

    // Shared iteration datapath, operating on the context selected by ptr
    always_comb begin
        zr2    = PROD_W'(zr_q[ptr_q]) * PROD_W'(zr_q[ptr_q]);
        zi2    = PROD_W'(zi_q[ptr_q]) * PROD_W'(zi_q[ptr_q]);
        zrzi   = PROD_W'(zr_q[ptr_q]) * PROD_W'(zi_q[ptr_q]);
        sq     = SQ_W'(zr2) + SQ_W'(zi2);
        diff   = SQ_W'(zr2) - SQ_W'(zi2);
        dbl    = SQ_W'(zrzi) <<< 1;
        escape = sq > ESC_LIM;
        zr_nxt = trunc_shift(diff) + cr_q[ptr_q];
        zi_nxt = trunc_shift(dbl) + ci_q[ptr_q];
    end

`ifdef MANDEL_CARDIOID_EN
    localparam int CW = 2 * DATA_WIDTH + 2;
    localparam int QW = 2 * CW;
    localparam logic signed [DATA_WIDTH:0] QUARTER = (DATA_WIDTH + 1)'(1) <<< (FRACT_WIDTH - 2);
    localparam logic signed [DATA_WIDTH:0] ONE     = (DATA_WIDTH + 1)'(1) <<< FRACT_WIDTH;
    localparam logic signed [CW-1:0]       BULB_R2 = CW'(1) <<< (2 * FRACT_WIDTH - 4);

    logic signed [DATA_WIDTH:0] cx, cb;
    logic signed [CW-1:0]       cx2, cb2, ci2, q2, qs;
    logic signed [QW-1:0]       card_lhs, card_rhs;

    // Exact-precision membership test so skipping never changes a result
    always_comb begin
        cx          = {in_cr[DATA_WIDTH-1], in_cr} - QUARTER;
        cb          = {in_cr[DATA_WIDTH-1], in_cr} + ONE;
        cx2         = CW'(cx) * CW'(cx);
        cb2         = CW'(cb) * CW'(cb);
        ci2         = CW'(in_ci) * CW'(in_ci);
        q2          = cx2 + ci2;
        qs          = q2 + (CW'(cx) <<< FRACT_WIDTH);
        card_lhs    = QW'(q2) * QW'(qs);
        card_rhs    = (QW'(ci2) <<< (2 * FRACT_WIDTH)) >>> 2;
        load_inside = (card_lhs <= card_rhs) || ((cb2 + ci2) <= BULB_R2);
    end
`else
    assign load_inside = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q[ptr_q];
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        out_load  = 1'b0;
        in_ready  = 1'b0;
        case (state_q[ptr_q])
            CTX_FREE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = load_inside ? CTX_DONE : CTX_RUN;
                end
            end
            CTX_RUN: begin
                if (escape || (iter_q[ptr_q] == iterations_max)) begin
                    finish    = 1'b1;
                    state_nxt = CTX_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            CTX_DONE: begin
                if (!out_valid || out_ready) begin
                    out_load  = 1'b1;
                    state_nxt = CTX_FREE;
                end
            end
            default: state_nxt = CTX_FREE;
        endcase
    end

    always_comb begin
        busy = out_valid;
        for (int i = 0; i < NUM_CTX; i++)
            if (state_q[i] != CTX_FREE) busy = 1'b1;
    end

    // Control: context states, slot pointer and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q          <= '0;
            out_valid      <= 1'b0;
            out_iterations <= '0;
            out_escaped    <= 1'b0;
            out_xpixel     <= '0;
            out_ypixel     <= '0;
            for (int i = 0; i < NUM_CTX; i++) state_q[i] <= CTX_FREE;
        end else begin
            ptr_q          <= ptr_q + 1'b1;
            state_q[ptr_q] <= state_nxt;
            if (out_load) begin
                out_valid      <= 1'b1;
                out_iterations <= iter_q[ptr_q];
                out_escaped    <= esc_q[ptr_q];
                out_xpixel     <= xpix_q[ptr_q];
                out_ypixel     <= ypix_q[ptr_q];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Per-context data; validity is carried entirely by state_q
    always_ff @(posedge clk) begin
        if (accept) begin
            zr_q[ptr_q]   <= '0;
            zi_q[ptr_q]   <= '0;
            cr_q[ptr_q]   <= in_cr;
            ci_q[ptr_q]   <= in_ci;
            iter_q[ptr_q] <= load_inside ? iterations_max : '0;
            esc_q[ptr_q]  <= 1'b0;
            xpix_q[ptr_q] <= in_xpixel;
            ypix_q[ptr_q] <= in_ypixel;
        end else if (step) begin
            zr_q[ptr_q]   <= zr_nxt;
            zi_q[ptr_q]   <= zi_nxt;
            iter_q[ptr_q] <= iter_q[ptr_q] + 1'b1;
        end else if (finish) begin
            esc_q[ptr_q]  <= escape;
        end
    end
endmodule

// File: tb/tb_mandelbrot_engine_mc.sv
// Directed self-checking bench for mandelbrot_engine_mc (default build, 25/20 fixed point).
module tb_mandelbrot_engine_mc;
    localparam int DW = 25;
    localparam int NC = 4;
    localparam logic signed [DW-1:0] ZERO  = 25'sd0;
    localparam logic signed [DW-1:0] ONE   = 25'sd1048576;
    localparam logic signed [DW-1:0] TWO   = 25'sd2097152;
    localparam logic signed [DW-1:0] M_TWO = -25'sd2097152;
    localparam logic signed [DW-1:0] HALF  = 25'sd524288;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] iterations_max;
    logic in_valid, in_ready;
    logic signed [DW-1:0] in_cr, in_ci;
    logic [9:0] in_xpixel, in_ypixel;
    logic out_valid, out_ready, out_escaped, busy;
    logic [15:0] out_iterations;
    logic [9:0] out_xpixel, out_ypixel;

    int total = 0;
    int bad = 0;

    mandelbrot_engine_mc dut (
        .clk(clk), .reset(reset), .iterations_max(iterations_max),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cr(in_cr), .in_ci(in_ci), .in_xpixel(in_xpixel), .in_ypixel(in_ypixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_iterations(out_iterations), .out_escaped(out_escaped),
        .out_xpixel(out_xpixel), .out_ypixel(out_ypixel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; iterations_max = 16'd100;
        in_cr = '0; in_ci = '0; in_xpixel = '0; in_ypixel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic submit(input logic signed [DW-1:0] cr, input logic signed [DW-1:0] ci,
                          input logic [9:0] x, input logic [9:0] y);
        bit done = 0;
        in_cr = cr; in_ci = ci; in_xpixel = x; in_ypixel = y; in_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            if (in_ready === 1'b1) done = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL submit_timeout: in_ready never seen for x=%0d", x);
        end
    endtask

    task automatic wait_result(output bit ok, output logic [15:0] it, output logic esc,
                               output logic [9:0] x, output logic [9:0] y);
        ok = 0; it = '0; esc = 1'b0; x = '0; y = '0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            if (out_valid === 1'b1) begin
                ok = 1; it = out_iterations; esc = out_escaped; x = out_xpixel; y = out_ypixel;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_iterations !== 16'd0) begin bad++; $display("FAIL reset_out_iter: got %0d want 0", out_iterations); end
        total++; if (out_xpixel !== 10'd0) begin bad++; $display("FAIL reset_out_x: got %0d want 0", out_xpixel); end
    endtask

    task automatic test_pixel(input string name, input logic signed [DW-1:0] cr,
                              input logic [15:0] lim, input logic [15:0] exp_it, input logic exp_esc,
                              input logic [9:0] x, input logic [9:0] y);
        bit ok; logic [15:0] it; logic esc; logic [9:0] rx, ry;
        do_reset();
        iterations_max = lim;
        submit(cr, ZERO, x, y);
        wait_result(ok, it, esc, rx, ry);
        total++;
        if (!ok) begin bad++; $display("FAIL %s_timeout: no out_valid, want iterations=%0d", name, exp_it); end
        else begin
            if (it !== exp_it) begin bad++; $display("FAIL %s_iter: got %0d want %0d", name, it, exp_it); end
            total++; if (esc !== exp_esc) begin bad++; $display("FAIL %s_esc: got %b want %b", name, esc, exp_esc); end
            total++; if (rx !== x) begin bad++; $display("FAIL %s_x: got %0d want %0d", name, rx, x); end
            total++; if (ry !== y) begin bad++; $display("FAIL %s_y: got %0d want %0d", name, ry, y); end
        end
        iterations_max = 16'd100;
    endtask

    task automatic test_back_to_back();
        bit ok; logic [15:0] it; logic esc; logic [9:0] rx, ry;
        logic [3:0] seen = '0;
        do_reset();
        for (int i = 0; i < NC; i++) begin
            in_valid = 1'b1; in_cr = (i % 2 == 1) ? ONE : TWO; in_ci = ZERO;
            in_xpixel = 10'(i); in_ypixel = 10'd0;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_after: got %b want 0", in_ready); end
        for (int n = 0; n < NC; n++) begin
            wait_result(ok, it, esc, rx, ry);
            total++;
            if (!ok) begin bad++; $display("FAIL b2b_timeout: result %0d missing", n); end
            else begin
                if (it !== ((rx % 2 == 1) ? 16'd3 : 16'd2)) begin
                    bad++; $display("FAIL b2b_iter: x=%0d got %0d want %0d", rx, it, (rx % 2 == 1) ? 3 : 2);
                end
                total++; if (esc !== 1'b1) begin bad++; $display("FAIL b2b_esc: x=%0d got %b want 1", rx, esc); end
                if (rx < 10'd4) seen[rx[1:0]] = 1'b1;
            end
        end
        total++; if (seen !== 4'hF) begin bad++; $display("FAIL b2b_tags: got %b want 1111", seen); end
    endtask

    task automatic test_stall();
        bit ok = 0; int unstable = 0; int n = 0; int cyc = 0;
        logic [9:0] held_x; logic [15:0] held_it;
        logic [3:0] seen = '0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < NC; i++) submit(TWO, ZERO, 10'(i), 10'd1);
        for (int k = 0; k < 200 && !ok; k++) begin
            if (out_valid === 1'b1) ok = 1; else @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL stall_first: out_valid=%b want 1", out_valid); end
        held_x = out_xpixel; held_it = out_iterations;
        repeat (50) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_xpixel !== held_x || out_iterations !== held_it) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_stable: got %0d changed cycles want 0", unstable); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b want 1", busy); end
        out_ready = 1'b1;
        while (n < NC && cyc < 4 * NC) begin
            if (out_valid === 1'b1) begin
                if (n == 0) begin
                    total++; if (out_xpixel !== held_x) begin bad++; $display("FAIL stall_held_x: got %0d want %0d", out_xpixel, held_x); end
                end
                total++; if (out_iterations !== 16'd2) begin bad++; $display("FAIL stall_iter: got %0d want 2", out_iterations); end
                if (out_xpixel < 10'd4) seen[out_xpixel[1:0]] = 1'b1;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        total++; if (n != NC) begin bad++; $display("FAIL stall_drain: got %0d results want %0d", n, NC); end
        total++; if (seen !== 4'hF) begin bad++; $display("FAIL stall_tags: got %b want 1111", seen); end
    endtask

    task automatic test_mid_reset();
        int stale = 0;
        do_reset();
        submit(M_TWO, ZERO, 10'd7, 10'd3);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mreset_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mreset_in_ready: got %b want 1", in_ready); end
        repeat (600) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL mreset_stale: got %0d valid cycles want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_pixel("c_zero", ZERO, 16'd100, 16'd100, 1'b0, 10'd11, 10'd5);
        test_pixel("c_two", TWO, 16'd100, 16'd2, 1'b1, 10'd12, 10'd6);
        test_pixel("c_one", ONE, 16'd100, 16'd3, 1'b1, 10'd13, 10'd7);
        test_pixel("c_mtwo", M_TWO, 16'd100, 16'd100, 1'b0, 10'd14, 10'd8);
        test_pixel("lim_zero", HALF, 16'd0, 16'd0, 1'b0, 10'd15, 10'd9);
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
